fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips_pkg.sv | 32 +++
 rtl/flopenrc.sv | 26 ++
 rtl/fetch_stage.sv | 164 ++++++++++++++++
 tb/tb_fetch_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage types: state encoding, IF/ID and skid records, PC arithmetic.
// No logic of its own; latency and backpressure are defined by the users of these types.
// All PC arithmetic is 32-bit modulo.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INC = 32'd4;
    localparam logic [WORD_W-1:0] NOP    = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] pcplus4;
    } ifid_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } skid_t;

    function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] cur);
        return cur + PC_INC;
    endfunction

endpackage

// File: rtl/flopenrc.sv
// Register with async reset to RESET_VAL, synchronous clear (wins over enable) and load enable.
// Latency: one clock edge from d to q.
// Backpressure: en low holds q.
module flopenrc #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives the imem request and fills the IF/ID register, with a one-word skid and redirect drain.
// Latency: an acked word appears on IF/ID at the edge after its ack.
// Backpressure: stall_d parks an acked word in the skid buffer and drops imem_req until decode accepts it.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d
);

    fetch_state_t      state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_next;
    logic [WORD_W-1:0] target;
    skid_t             skid;
    skid_t             src;
    ifid_t             ifid_q;
    ifid_t             ifid_d;
    logic              ack;
    logic              pc_en;
    logic              ifid_load;
    logic              ifid_clr;

    assign imem_req  = ~reset & (state != HOLD);
    assign imem_addr = pc;
    assign ack       = imem_ack & (state != HOLD);

    always_comb begin
        pc_en     = 1'b0;
        pc_next   = pc;
        ifid_load = 1'b0;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    if (ack) begin
                        pc_en   = 1'b1;
                        pc_next = redirect_pc;
                    end
                end else if (ack) begin
                    pc_en     = 1'b1;
                    pc_next   = next_pc(pc);
                    ifid_load = ~stall_d;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_en   = 1'b1;
                    pc_next = redirect_pc;
                end else begin
                    ifid_load = ~stall_d;
                end
            end
            DRAIN: begin
                // The outstanding word is dropped; a redirect arriving with the ack is newest.
                if (ack) begin
                    pc_en   = 1'b1;
                    pc_next = redirect_valid ? redirect_pc : target;
                end
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase

        if (state == HOLD) begin
            src = skid;
        end else begin
            src.instr = imem_rdata;
            src.pc    = pc;
        end
        ifid_d.valid   = 1'b1;
        ifid_d.instr   = src.instr;
        ifid_d.pc      = src.pc;
        ifid_d.pcplus4 = next_pc(src.pc);

        // Flush kills only what sits in or would enter IF/ID this edge; a word parked
        // in the skid under stall is the next instruction and survives.
        ifid_clr = redirect_valid | flush_d | (~stall_d & ~ifid_load);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            skid.instr <= NOP;
            skid.pc    <= '0;
            target     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        if (!ack) begin
                            target <= redirect_pc;
                            state  <= DRAIN;
                        end
                    end else if (ack && stall_d) begin
                        skid.instr <= imem_rdata;
                        skid.pc    <= pc;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid || !stall_d) begin
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        target <= redirect_pc;
                    end
                    if (ack) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    flopenrc #(
        .WIDTH     (WORD_W),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .clear (1'b0),
        .d     (pc_next),
        .q     (pc)
    );

    flopenrc #(
        .WIDTH     ($bits(ifid_t)),
        .RESET_VAL ('0)
    ) u_ifid_reg (
        .clk   (clk),
        .reset (reset),
        .en    (ifid_load),
        .clear (ifid_clr),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign valid_d   = ifid_q.valid;
    assign instr_d   = ifid_q.instr;
    assign pc_d      = ifid_q.pc;
    assign pcplus4_d = ifid_q.pcplus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector tables plus a randomized run against a queue-based reference model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_d;
    logic        flush_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pcplus4_d      (pcplus4_d),
        .valid_d        (valid_d)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pcd;
    } vec_t;

    // Inputs are held for one cycle; expectations describe outputs seen during that cycle.
    task automatic apply(input vec_t v, input string tag);
        stall_d        = v.stall;
        flush_d        = v.flush;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        imem_ack       = v.ack;
        @(negedge clk);
        check($sformatf("%s req", tag), 32'(imem_req), 32'(v.e_req));
        check($sformatf("%s addr", tag), imem_addr, v.e_addr);
        check($sformatf("%s valid_d", tag), 32'(valid_d), 32'(v.e_valid));
        if (v.e_valid) begin
            check($sformatf("%s pc_d", tag), pc_d, v.e_pcd);
            check($sformatf("%s instr_d", tag), instr_d, mem_word(v.e_pcd));
            check($sformatf("%s pcplus4_d", tag), pcplus4_d, 32'(v.e_pcd + 32'd4));
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[18];
    vec_t seq1[10];
    vec_t seq2[5];

    // Reference model: pending redirect and skid kept as queues, IF/ID as plain fields.
    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } fetched_t;

    logic [31:0] m_pc;
    fetched_t    held[$];
    logic [31:0] pend[$];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;

    task automatic model_reset();
        m_pc    = RST_PC;
        held.delete();
        pend.delete();
        m_valid = 1'b0;
        m_instr = '0;
        m_pcd   = '0;
    endtask

    task automatic model_step(input logic stall, input logic flush, input logic redir,
                              input logic [31:0] rpc, input logic ack);
        fetched_t w;
        logic     got;
        got = ack && (held.size() == 0);
        if (held.size() != 0) begin
            if (redir) begin
                held.delete();
                m_pc    = rpc;
                m_valid = 1'b0;
            end else if (!stall) begin
                w = held.pop_front();
                if (flush) m_valid = 1'b0;
                else begin
                    m_valid = 1'b1; m_instr = w.word; m_pcd = w.pc;
                end
            end else if (flush) begin
                m_valid = 1'b0;
            end
        end else if (pend.size() != 0) begin
            if (redir) pend[0] = rpc;
            if (got) m_pc = pend.pop_front();
            m_valid = 1'b0;
        end else if (redir) begin
            if (got) m_pc = rpc;
            else pend.push_back(rpc);
            m_valid = 1'b0;
        end else if (got) begin
            w.word = mem_word(m_pc);
            w.pc   = m_pc;
            m_pc   = m_pc + 32'd4;
            if (stall) begin
                held.push_back(w);
                if (flush) m_valid = 1'b0;
            end else if (flush) begin
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1; m_instr = w.word; m_pcd = w.pc;
            end
        end else if (flush || !stall) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        //          stall flush redir rpc           ack  req addr          valid pc_d
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,       1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,       1'b1, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,       1'b1, 32'h4};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,       1'b1, 32'h4};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'hC,       1'b1, 32'h4};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,       1'b1, 32'h4};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'hC,       1'b1, 32'h4};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,       1'b1, 32'h8};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h100,      1'b1, 1'b1, 32'h10,      1'b1, 32'hC};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100,     1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,     1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h104,     1'b1, 32'h100};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h20,       1'b1, 1'b1, 32'h104,     1'b0, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h200,      1'b0, 1'b1, 32'h20,      1'b0, 32'h0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h20,      1'b0, 32'h0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h20,      1'b0, 32'h0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200,     1'b0, 32'h0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h204,     1'b1, 32'h200};

        // flush while a word is parked, then latest-wins redirect during drain
        seq1[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h204,     1'b0, 32'h0};
        seq1[1] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h208,     1'b1, 32'h204};
        seq1[2] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h20C,     1'b1, 32'h204};
        seq1[3] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h20C,     1'b0, 32'h0};
        seq1[4] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h20C,     1'b1, 32'h208};
        seq1[5] = '{1'b0, 1'b0, 1'b1, 32'h400,      1'b0, 1'b1, 32'h20C,     1'b0, 32'h0};
        seq1[6] = '{1'b0, 1'b0, 1'b1, 32'h500,      1'b0, 1'b1, 32'h20C,     1'b0, 32'h0};
        seq1[7] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h20C,     1'b0, 32'h0};
        seq1[8] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h500,     1'b0, 32'h0};
        seq1[9] = '{1'b0, 1'b0, 1'b1, 32'h600,      1'b0, 1'b1, 32'h500,     1'b0, 32'h0};

        // after reset in drain, then PC wrap
        seq2[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, RST_PC,      1'b0, 32'h0};
        seq2[1] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h4,      1'b1, 32'h0};
        seq2[2] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
        seq2[3] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,       1'b1, 32'hFFFF_FFFC};
        seq2[4] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,       1'b0, 32'h0};

        reset          = 1'b1;
        stall_d        = 1'b0;
        flush_d        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ack       = 1'b1;
        @(negedge clk);
        check("reset req", 32'(imem_req), 32'h0);
        check("reset addr", imem_addr, RST_PC);
        check("reset valid_d", 32'(valid_d), 32'h0);
        check("reset instr_d", instr_d, 32'h0);
        check("reset pc_d", pc_d, 32'h0);
        check("reset pcplus4_d", pcplus4_d, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("tbl%0d", i));
        for (int i = 0; i < 10; i++) apply(seq1[i], $sformatf("seq1_%0d", i));

        // reset pulse while a redirect is draining
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        reset          = 1'b1;
        #2;
        check("drain reset req", 32'(imem_req), 32'h0);
        check("drain reset addr", imem_addr, RST_PC);
        check("drain reset valid_d", 32'(valid_d), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) apply(seq2[i], $sformatf("seq2_%0d", i));

        // randomized run against the reference model
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 199) == 0);
            stall_d        = ($urandom_range(0, 9) < 3);
            flush_d        = ($urandom_range(0, 9) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            imem_ack       = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (reset) begin
                model_reset();
                check($sformatf("rnd%0d reset req", n), 32'(imem_req), 32'h0);
                check($sformatf("rnd%0d reset addr", n), imem_addr, RST_PC);
                check($sformatf("rnd%0d reset valid_d", n), 32'(valid_d), 32'h0);
            end else begin
                check($sformatf("rnd%0d req", n), 32'(imem_req), 32'(held.size() == 0));
                check($sformatf("rnd%0d addr", n), imem_addr, m_pc);
                check($sformatf("rnd%0d valid_d", n), 32'(valid_d), 32'(m_valid));
                if (m_valid) begin
                    check($sformatf("rnd%0d instr_d", n), instr_d, m_instr);
                    check($sformatf("rnd%0d pc_d", n), pc_d, m_pcd);
                    check($sformatf("rnd%0d pcplus4_d", n), pcplus4_d, 32'(m_pcd + 32'd4));
                end
                model_step(stall_d, flush_d, redirect_valid, redirect_pc, imem_ack);
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
